// File: rtl/modmul_rr_arbiter.sv
// modmul_rr_arbiter: round-robin front end that time-shares one modular multiplier among N requesters.
// Latency: gnt -> resp_valid is L+3 cycles, where L is the core's start-to-done latency. Back-to-back service needs at least 5 cycles plus L.
// Backpressure: requesters hold req high until gnt. Requests raised while busy are only looked at once the arbiter is back in IDLE.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset (the core shares this reset)
//   req[N]                      per-requester request levels
//   a_in/b_in/m_in[N*W]         operands; requester i owns slice [i*W +: W]
//   gnt[N]                      one-hot, one-cycle pulse when requester i's operands are captured
//   resp_valid/resp_id/result   one-cycle response pulse, with the owner's index; result and id hold until the next response
//   busy                        high from grant through the RESP cycle
//   mm_start/mm_a/mm_b/mm_m     core start pulse and registered operands
//   mm_result/mm_done           core result and done level (done is high when the core is idle)
module modmul_rr_arbiter #(
  parameter int W   = 260,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  input  logic [N*W-1:0]   m_in,
  output logic [N-1:0]     gnt,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [W-1:0]     result,
  output logic             busy,
  output logic             mm_start,
  output logic [W-1:0]     mm_a,
  output logic [W-1:0]     mm_b,
  output logic [W-1:0]     mm_m,
  input  logic [W-1:0]     mm_result,
  input  logic             mm_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           mm_start_q, mm_start_d;
  logic           busy_q, busy_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   mm_a_q, mm_a_d;
  logic [W-1:0]   mm_b_q, mm_b_d;
  logic [W-1:0]   mm_m_q, mm_m_d;

  // Winner search: scan cyclically from ptr. The candidate index is computed
  // with one extra bit so that the wrap is taken mod N rather than mod 2^IDW.
  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;

  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(N)) begin
        cand_sum = cand_sum - (IDW+1)'(N);
      end
      cand = cand_sum[IDW-1:0];
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Operand mux, decoded with constant slice offsets.
  logic [W-1:0] win_a, win_b, win_m;

  always_comb begin
    win_a = '0;
    win_b = '0;
    win_m = '0;
    for (int i = 0; i < N; i++) begin
      if (win_id == IDW'(i)) begin
        win_a = a_in[i*W +: W];
        win_b = b_in[i*W +: W];
        win_m = m_in[i*W +: W];
      end
    end
  end

  // The pointer moves to the requester after the winner. The wrap is taken mod N.
  logic [IDW-1:0] ptr_next;
  assign ptr_next = (win_id == IDW'(N-1)) ? '0 : win_id + IDW'(1);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cur_id_d     = cur_id_q;
    gnt_d        = '0;
    mm_start_d   = 1'b0;
    busy_d       = busy_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    result_d     = result_q;
    mm_a_d       = mm_a_q;
    mm_b_d       = mm_b_q;
    mm_m_d       = mm_m_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          mm_a_d        = win_a;
          mm_b_d        = win_b;
          mm_m_d        = win_m;
          cur_id_d      = win_id;
          gnt_d[win_id] = 1'b1;
          mm_start_d    = 1'b1;
          busy_d        = 1'b1;
          ptr_d         = ptr_next;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      // The core's done may still read high (stale idle) here, so it is not sampled.
      S_GAP:   state_d = S_WAIT;
      S_WAIT: begin
        if (mm_done) begin
          result_d     = mm_result;
          resp_id_d    = cur_id_q;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cur_id_q     <= '0;
      gnt_q        <= '0;
      mm_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      result_q     <= '0;
      mm_a_q       <= '0;
      mm_b_q       <= '0;
      mm_m_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_id_q     <= cur_id_d;
      gnt_q        <= gnt_d;
      mm_start_q   <= mm_start_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      result_q     <= result_d;
      mm_a_q       <= mm_a_d;
      mm_b_q       <= mm_b_d;
      mm_m_q       <= mm_m_d;
    end
  end

  assign gnt        = gnt_q;
  assign mm_start   = mm_start_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign result     = result_q;
  assign mm_a       = mm_a_q;
  assign mm_b       = mm_b_q;
  assign mm_m       = mm_m_q;

endmodule

// File: doc/modmul_rr_arbiter.md
Name: modmul_rr_arbiter

Overview:
- Shares one modular-multiplier instance (start/done handshake; operands a, b, m; W-bit result) among N requesters using round-robin arbitration.
- Sits between up to N exponentiation/arithmetic controllers and a single multiplier core, so the core is instantiated once rather than per controller.
- Runs one multiplication at a time: latches the winner's operands, sequences the core's start pulse, waits for done, and returns the result tagged with the requester index.

Parameters:
- W, 260, operand/result width in bits.
- N, 4, number of requesters (≥2).
- IDW, 2, width of requester index; must be ≥ ceil(log2(N)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; bit i held high with operands stable until gnt[i].
- a_in  in  N*W  operand a; requester i owns bits [i*W +: W].
- b_in  in  N*W  operand b, same slicing.
- m_in  in  N*W  modulus, same slicing.
- gnt  out  N  one-hot, one-cycle pulse: operands of requester i captured.
- resp_valid  out  1  one-cycle pulse: result valid.
- resp_id  out  IDW  requester index of the current/last response.
- result  out  W  product; held until the next response.
- busy  out  1  high from grant until the end of the RESP cycle.
- mm_start  out  1  multiplier start, one-cycle pulse.
- mm_a, mm_b, mm_m  out  W each  multiplier operands, registered, stable from the start pulse until done is sampled.
- mm_result  in  W  multiplier result.
- mm_done  in  1  multiplier done/idle level; high when idle; drops the cycle after start is sampled; re-rises when result valid.

Behaviour:
- Reset values:
  - All outputs are 0: gnt, resp_valid, resp_id, result, busy, mm_start, mm_a/b/m.
  - Round-robin pointer ptr = 0; state = IDLE.
- States: IDLE, ISSUE, GAP, WAIT, RESP.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning cyclically from ptr (ptr, ptr+1, …, N-1, 0, …).
  - At the edge: mm_a/b/m ← winner's slices; cur_id ← winner; gnt[winner] ← 1; mm_start ← 1; busy ← 1; ptr ← (winner+1) mod N; state ← ISSUE.
  - If no request: stay in IDLE; all pulses 0.
- ISSUE (mm_start = 1, gnt high this cycle): at the edge, mm_start ← 0, gnt ← 0, state ← GAP.
- GAP: mm_done is ignored here, because the core may still show its stale idle-high done. At the edge, state ← WAIT.
- WAIT:
  - mm_done sampled every cycle.
  - When it is 1: result ← mm_result; resp_id ← cur_id; resp_valid ← 1; state ← RESP.
  - No timeout; waits indefinitely.
- RESP (resp_valid = 1): at the edge, resp_valid ← 0, busy ← 0, state ← IDLE.
  - A request present in the following IDLE cycle is granted then, so back-to-back service has a minimum spacing of 5 cycles per operation plus core latency.
- Latency: resp_valid rises L+3 cycles after gnt rises, where L = cycles from the start-sampling edge to done re-rising (L ≥ 2).
- Request withdrawal: req[i] dropped before gnt[i] means no service and no state change.
  - req[i] still high after gnt[i] is treated as a new request, arbitrated normally.
- Requests arriving while busy are not captured; they are considered only in IDLE.
- ptr advances only on a grant. Width wrap: ptr counts mod N, not mod 2^IDW.
- Reset mid-operation (any state):
  - Everything returns to its reset value next cycle; the in-flight result is discarded; no resp_valid.
  - The core shares reset.

Test Plan:
- Single request, W=8, core model L=4: req[0], a=3, b=5, m=7.
  - gnt[0] 1 cycle; mm_start 1 cycle with mm_a=3, mm_b=5, mm_m=7.
  - resp_valid 1 cycle, 7 cycles after gnt; resp_id=0, result=1.
  - busy high gnt→RESP.
- Simultaneous requests: req=4'b1111 held after reset.
  - Grant order 1→2→3→0 is wrong; required order 0,1,2,3.
  - Then, with req=4'b0101 held: 0,2,0,2.
- Fairness: req[1] held continuously; req[3] raised during req[1]'s WAIT.
  - Next grant is 3, then 1; req[1] never starves req[3].
- Withdrawal: req[2] pulsed for 1 cycle while busy with requester 0.
  - Never granted; no resp_id=2 response.
- Stale done: core model holds mm_done=1 through the GAP cycle and drops it 1 cycle after start.
  - No early resp_valid; the result equals the model's final value.
- Reset mid-WAIT: assert reset 1 cycle.
  - All outputs 0; no resp_valid for the aborted op.
  - With req=4'b1000, the first grant is gnt[3] (ptr restarted at 0).
